ip_tone_psg: RTL and testbench



---
 rtl/ip_tone_psg.sv | 180 ++++++++++++++++++
 tb/tb_ip_tone_psg.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_tone_psg.sv
// Host-programmable square-wave tone generator on the MSX I/O bus (index/data port pair).
// Optional IP_TONE_PSG_READBACK_EN: data-port reads return the selected register R0-R4.
module ip_tone_psg #(
  parameter logic [7:0] io_address = 8'h10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] bus_address,
  input  logic        bus_io,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [7:0]  bus_write_data,
  output logic        bus_io_cs,
  output logic        bus_read_ready,
  output logic [7:0]  bus_read_data,
  output logic [7:0]  sound_level,
  output logic        busy
);

  localparam logic [7:0] data_address = io_address + 8'd1;
  localparam logic [2:0] reg_freq_l   = 3'd0;
  localparam logic [2:0] reg_freq_h   = 3'd1;
  localparam logic [2:0] reg_level    = 3'd2;
  localparam logic [2:0] reg_ctrl     = 3'd3;
  localparam logic [2:0] reg_dur      = 3'd4;
  localparam logic [9:0] presc_last   = 10'd1023;

  logic        hit_index;
  logic        hit_data;
  logic        wr_index;
  logic        wr_data;
  logic        wr_ctrl;
  logic        rd_hit;
  logic        unused;

  logic [2:0]  index,     index_nxt;
  logic [15:0] freq,      freq_nxt;
  logic [7:0]  level,     level_nxt;
  logic        en,        en_nxt;
  logic        oneshot,   oneshot_nxt;
  logic [7:0]  dur,       dur_nxt;
  logic [15:0] div_count, div_count_nxt;
  logic        phase,     phase_nxt;
  logic [9:0]  presc,     presc_nxt;
  logic [7:0]  dur_count, dur_count_nxt;
  logic [7:0]  sound_nxt;
  logic        read_ready_nxt;
  logic [7:0]  read_data_nxt;

  // Only the low address byte selects the ports.
  assign unused    = ^bus_address[15:8];
  assign hit_index = bus_address[7:0] == io_address;
  assign hit_data  = bus_address[7:0] == data_address;
  assign bus_io_cs = bus_io && (hit_index || hit_data);
  assign wr_index  = bus_write && bus_io && hit_index;
  assign wr_data   = bus_write && bus_io && hit_data;
  assign wr_ctrl   = wr_data && (index == reg_ctrl);
  assign rd_hit    = bus_read && bus_io_cs;
  assign busy      = en;

  always_comb begin
    index_nxt      = index;
    freq_nxt       = freq;
    level_nxt      = level;
    en_nxt         = en;
    oneshot_nxt    = oneshot;
    dur_nxt        = dur;
    div_count_nxt  = div_count;
    phase_nxt      = phase;
    presc_nxt      = presc;
    dur_count_nxt  = dur_count;
    read_ready_nxt = 1'b0;
    read_data_nxt  = 8'h00;

    if (wr_index) begin
      index_nxt = bus_write_data[2:0];
    end
    if (wr_data) begin
      case (index)
        reg_freq_l: freq_nxt[7:0]  = bus_write_data;
        reg_freq_h: freq_nxt[15:8] = bus_write_data;
        reg_level:  level_nxt      = bus_write_data;
        reg_dur:    dur_nxt        = bus_write_data;
        default:    ;
      endcase
    end

    // Tone divider and one-shot prescaler; idle state is all-zero.
    if (!en) begin
      div_count_nxt = 16'd0;
      phase_nxt     = 1'b0;
      presc_nxt     = 10'd0;
    end else if (tick) begin
      if (div_count == 16'd0) begin
        div_count_nxt = freq;
        phase_nxt     = ~phase;
      end else begin
        div_count_nxt = div_count - 16'd1;
      end
      presc_nxt = presc + 10'd1;
      if ((presc == presc_last) && oneshot) begin
        if (dur_count == 8'd0) begin
          en_nxt = 1'b0;
        end else begin
          dur_count_nxt = dur_count - 8'd1;
        end
      end
    end

    // A CTRL write overrides expiry; enabling preloads FREQ so the first toggle lands FREQ+1 ticks later.
    if (wr_ctrl) begin
      en_nxt      = bus_write_data[0];
      oneshot_nxt = bus_write_data[1];
      if (!en && bus_write_data[0]) begin
        div_count_nxt = freq;
        phase_nxt     = 1'b0;
      end
      if (bus_write_data[0] && bus_write_data[1]) begin
        dur_count_nxt = dur;
        presc_nxt     = 10'd0;
      end
    end

    sound_nxt = (en_nxt && phase_nxt && (freq_nxt != 16'd0)) ? level_nxt : 8'h00;

    if (rd_hit) begin
      read_ready_nxt = 1'b1;
      if (hit_index) begin
        read_data_nxt = {5'd0, index};
      end else begin
`ifdef IP_TONE_PSG_READBACK_EN
        case (index)
          reg_freq_l: read_data_nxt = freq[7:0];
          reg_freq_h: read_data_nxt = freq[15:8];
          reg_level:  read_data_nxt = level;
          reg_ctrl:   read_data_nxt = {6'd0, oneshot, en};
          reg_dur:    read_data_nxt = dur;
          default:    read_data_nxt = 8'h00;
        endcase
`else
        read_data_nxt = 8'h00;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index          <= 3'd0;
      freq           <= 16'd0;
      level          <= 8'h00;
      en             <= 1'b0;
      oneshot        <= 1'b0;
      dur            <= 8'h00;
      div_count      <= 16'd0;
      phase          <= 1'b0;
      presc          <= 10'd0;
      dur_count      <= 8'h00;
      sound_level    <= 8'h00;
      bus_read_ready <= 1'b0;
      bus_read_data  <= 8'h00;
    end else begin
      index          <= index_nxt;
      freq           <= freq_nxt;
      level          <= level_nxt;
      en             <= en_nxt;
      oneshot        <= oneshot_nxt;
      dur            <= dur_nxt;
      div_count      <= div_count_nxt;
      phase          <= phase_nxt;
      presc          <= presc_nxt;
      dur_count      <= dur_count_nxt;
      sound_level    <= sound_nxt;
      bus_read_ready <= read_ready_nxt;
      bus_read_data  <= read_data_nxt;
    end
  end

endmodule

// File: tb/tb_ip_tone_psg.sv
// Bench for ip_tone_psg: tick-count tone model compared every cycle, plus directed literal cases.
module tb_ip_tone_psg;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [15:0] bus_address;
  logic        bus_io;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_write_data;
  logic        bus_io_cs;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;
  logic [7:0]  sound_level;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int tick_mode = 0;
  bit cmp_on = 1'b0;

  int m_idx, m_freq, m_level, m_dur, m_durlen, m_k, m_osk;
  bit m_en, m_os;
  int exp_sound, exp_rr, exp_rd;

  ip_tone_psg #(.io_address(8'h10)) dut (
    .clk(clk), .reset(reset), .tick(tick), .bus_address(bus_address), .bus_io(bus_io),
    .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
    .bus_io_cs(bus_io_cs), .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data),
    .sound_level(sound_level), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    bus_address    = {8'($urandom), a};
    bus_io         = 1'b1;
    bus_write      = 1'b1;
    bus_write_data = d;
    step();
    bus_write = 1'b0;
    bus_io    = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a);
    bus_address = {8'($urandom), a};
    bus_io      = 1'b1;
    bus_read    = 1'b1;
    step();
    bus_read = 1'b0;
    bus_io   = 1'b0;
  endtask

  task automatic set_reg(input int r, input int v);
    bus_wr(8'h10, 8'(r));
    bus_wr(8'h11, 8'(v));
  endtask

  function automatic int reg_value(input int idx);
    case (idx)
      0: return m_freq & 'hFF;
      1: return (m_freq >> 8) & 'hFF;
      2: return m_level;
      3: return (int'(m_os) << 1) | int'(m_en);
      4: return m_dur;
      default: return 0;
    endcase
  endfunction

  // Tick source: off, every cycle, or random.
  initial forever begin
    @(posedge clk);
    #1;
    case (tick_mode)
      1: tick = 1'b1;
      2: tick = ($urandom_range(0, 2) == 0);
      default: tick = 1'b0;
    endcase
  end

  // Reference model: tone state is the tick count since enable; phase = (k / (FREQ+1)) mod 2.
  initial forever begin
    logic [7:0] a;
    bit hi, hd, en0;
    int d;
    @(posedge clk);
    a  = bus_address[7:0];
    hi = bus_io && (a == 8'h10);
    hd = bus_io && (a == 8'h11);
    d  = int'(bus_write_data);
    if (reset) begin
      m_idx = 0; m_freq = 0; m_level = 0; m_dur = 0; m_durlen = 0;
      m_k = 0; m_osk = 0; m_en = 1'b0; m_os = 1'b0;
      exp_rr = 0; exp_rd = 0;
    end else begin
      exp_rr = (bus_read && (hi || hd)) ? 1 : 0;
      exp_rd = 0;
      if (bus_read && hi) exp_rd = m_idx;
`ifdef IP_TONE_PSG_READBACK_EN
      else if (bus_read && hd) exp_rd = reg_value(m_idx);
`endif
      en0 = m_en;
      if (m_en && tick) begin
        m_k++;
        m_osk++;
        if (m_os && (m_osk == (m_durlen + 1) * 1024)) m_en = 1'b0;
      end
      if (bus_write && hi) m_idx = d & 7;
      if (bus_write && hd) begin
        case (m_idx)
          0: m_freq = (m_freq & 'hFF00) | d;
          1: m_freq = (m_freq & 'h00FF) | (d << 8);
          2: m_level = d;
          3: begin
            m_en = (d & 1) != 0;
            m_os = (d & 2) != 0;
            if (!en0 && m_en) m_k = 0;
            if (m_en && m_os) begin
              m_osk = 0;
              m_durlen = m_dur;
            end
          end
          4: m_dur = d;
          default: ;
        endcase
      end
    end
    exp_sound = (m_en && (m_freq != 0) && (((m_k / (m_freq + 1)) % 2) == 1)) ? m_level : 0;
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("sound_level", int'(sound_level), exp_sound);
      chk("busy", int'(busy), int'(m_en));
      chk("bus_read_ready", int'(bus_read_ready), exp_rr);
      chk("bus_read_data", int'(bus_read_data), exp_rd);
      chk("bus_io_cs", int'(bus_io_cs),
          int'(bus_io && ((bus_address[7:0] == 8'h10) || (bus_address[7:0] == 8'h11))));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat [9];
    int cnt;
    int r;
    logic [7:0] d;
    pat = '{8'h00, 8'h00, 8'h00, 8'hCC, 8'hCC, 8'hCC, 8'h00, 8'h00, 8'h00};
    reset = 1'b1; tick = 1'b0; bus_address = 16'h0; bus_io = 1'b0;
    bus_read = 1'b0; bus_write = 1'b0; bus_write_data = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    cmp_on = 1'b1;
    chk("reset_sound", int'(sound_level), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(bus_read_ready), 0);

    // Index readback after reset.
    bus_rd(8'h10);
    chk("idx_read_ready", int'(bus_read_ready), 1);
    chk("idx_read_data", int'(bus_read_data), 0);
    step();
    chk("idx_read_ready_drop", int'(bus_read_ready), 0);

    // FREQ=2: level alternates every 3 ticks, first high 3 ticks after enable.
    tick_mode = 1;
    set_reg(0, 2);
    set_reg(1, 0);
    set_reg(2, 8'hCC);
    set_reg(3, 1);
    for (int i = 0; i < 9; i++) begin
      chk("tone_pattern", int'(sound_level), int'(pat[i]));
      step();
    end

`ifdef IP_TONE_PSG_READBACK_EN
    bus_wr(8'h10, 8'h02);
    bus_rd(8'h11);
    chk("readback_level", int'(bus_read_data), 8'hCC);
`else
    bus_wr(8'h10, 8'h02);
    bus_rd(8'h11);
    chk("readback_disabled", int'(bus_read_data), 0);
    chk("readback_ready", int'(bus_read_ready), 1);
`endif

    // FREQ=0 keeps output silent while busy.
    set_reg(3, 0);
    set_reg(0, 0);
    set_reg(3, 1);
    repeat (5) step();
    chk("freq0_sound", int'(sound_level), 0);
    chk("freq0_busy", int'(busy), 1);

    // Reset mid-tone.
    set_reg(3, 0);
    set_reg(0, 1);
    set_reg(3, 1);
    repeat (7) step();
    reset = 1'b1;
    step();
    chk("midreset_sound", int'(sound_level), 0);
    chk("midreset_busy", int'(busy), 0);
    reset = 1'b0;

    // One-shot DUR=2 lasts 3*1024 ticks.
    set_reg(0, 2);
    set_reg(2, 8'hCC);
    set_reg(4, 2);
    set_reg(3, 3);
    cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy) break;
      cnt++;
      step();
    end
    chk("oneshot_len", cnt, 3072);
    chk("oneshot_silent", int'(sound_level), 0);

    // CTRL write on the expiry tick keeps EN and restarts the duration.
    set_reg(4, 0);
    set_reg(3, 3);
    repeat (1023) step();
    bus_wr(8'h11, 8'h03);
    chk("expiry_write_busy", int'(busy), 1);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      cnt++;
      step();
    end
    chk("expiry_restart_len", cnt, 1024);

    // Randomized traffic against the model.
    tick_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 49);
      if (r < 8) begin
        bus_wr(8'h10, 8'($urandom));
      end else if (r < 24) begin
        d = 8'($urandom);
        case (m_idx)
          0: if (m_en) step(); else bus_wr(8'h11, 8'($urandom_range(0, 6)));
          1: if (m_en) step(); else bus_wr(8'h11, ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00);
          4: bus_wr(8'h11, 8'($urandom_range(0, 1)));
          default: bus_wr(8'h11, d);
        endcase
      end else if (r < 34) begin
        bus_rd($urandom_range(0, 1) == 0 ? 8'h10 : 8'h11);
      end else if (r < 40) begin
        bus_address    = {8'($urandom), ($urandom_range(0, 1) == 0) ? 8'h11 : 8'h12};
        bus_io         = (bus_address[7:0] == 8'h12);
        bus_write      = 1'($urandom);
        bus_read       = 1'($urandom);
        bus_write_data = 8'($urandom);
        step();
        bus_io = 1'b0; bus_write = 1'b0; bus_read = 1'b0;
      end else if (r < 49) begin
        repeat ($urandom_range(1, 5)) step();
      end else begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
